// File: rtl/prio_scan_encoder.sv
// Sequential priority scan encoder: captures a request vector, then reports every set bit's index one beat at a time.
// Optional feature macro PRIO_SCAN_POPCOUNT_EN adds out_count (popcount of the captured vector).
module prio_scan_encoder #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PRIO_SCAN_POPCOUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pend;
  logic             r_dir;
  logic             r_none;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_clr;
  logic             w_le1;

  // Priority pick: last match wins, so loop direction selects MSB-first or LSB-first
  always_comb begin
    w_idx = '0;
    if (r_dir) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (r_pend[i]) w_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_pend[i]) w_idx = IDX_W'(i);
      end
    end
  end

  assign w_clr = WIDTH'(1) << w_idx;
  assign w_le1 = ((r_pend & (r_pend - WIDTH'(1))) == '0);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_valid ? w_idx : '0;
  assign out_last  = r_out_valid & w_le1;
  assign out_none  = r_out_valid & r_none;

`ifdef PRIO_SCAN_POPCOUNT_EN
  logic [IDX_W:0] r_count;
  logic [IDX_W:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pop = w_pop + (IDX_W+1)'(in_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_count <= w_pop;
    end
  end

  assign out_count = r_count;
`endif

  // Control FSM; in_ready/out_valid are flops that mirror the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_dir       <= 1'b0;
      r_none      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pend      <= in_vec;
            r_dir       <= in_dir;
            r_none      <= (in_vec == '0);
            r_state     <= S_SCAN;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_SCAN: begin
          if (out_ready) begin
            r_pend <= r_pend & ~w_clr;
            if (w_le1) begin
              r_state     <= S_IDLE;
              r_none      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed self-checking bench for prio_scan_encoder (WIDTH=16 and WIDTH=5 instances).
module tb_prio_scan_encoder;

  logic        clk;
  logic        rst_n;

  logic [15:0] in_vec;
  logic        in_dir, in_valid, out_ready;
  logic        in_ready, out_none, out_last, out_valid;
  logic [3:0]  out_idx;

  logic [4:0]  v5_vec;
  logic        v5_dir, v5_valid, v5_oready;
  logic        v5_iready, v5_none, v5_last, v5_ovalid;
  logic [2:0]  v5_idx;

`ifdef PRIO_SCAN_POPCOUNT_EN
  logic [4:0]  out_count;
  logic [3:0]  v5_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  prio_scan_encoder #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_vec(in_vec), .in_dir(in_dir), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_none(out_none), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef PRIO_SCAN_POPCOUNT_EN
    , .out_count(out_count)
`endif
  );

  prio_scan_encoder #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_vec(v5_vec), .in_dir(v5_dir), .in_valid(v5_valid), .in_ready(v5_iready),
    .out_idx(v5_idx), .out_none(v5_none), .out_last(v5_last),
    .out_valid(v5_ovalid), .out_ready(v5_oready)
`ifdef PRIO_SCAN_POPCOUNT_EN
    , .out_count(v5_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic last, input logic none);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".none"},  32'(out_none),  32'(none));
    chk({tag, ".rdy"},   32'(in_ready),  32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    int exp3 [8];
    exp3 = '{0, 2, 5, 7, 8, 10, 13, 15};

    rst_n = 1'b0;
    in_vec = '0; in_dir = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    v5_vec = '0; v5_dir = 1'b0; v5_valid = 1'b0; v5_oready = 1'b0;
    #12;
    chk("rst.rdy",   32'(in_ready),  32'd1);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.idx",   32'(out_idx),   32'd0);
    chk("rst.none",  32'(out_none),  32'd0);
    chk("rst.last",  32'(out_last),  32'd0);
`ifdef PRIO_SCAN_POPCOUNT_EN
    chk("rst.count", 32'(out_count), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // 8001 MSB-first
    in_vec = 16'h8001; in_dir = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t1.b0", 15, 1'b0, 1'b0);
`ifdef PRIO_SCAN_POPCOUNT_EN
    chk("t1.count", 32'(out_count), 32'd2);
`endif
    step();
    chk_beat("t1.b1", 0, 1'b1, 1'b0);
    step();
    chk_idle("t1.end");

    // all-zero vector
    in_vec = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t2.b0", 0, 1'b1, 1'b1);
`ifdef PRIO_SCAN_POPCOUNT_EN
    chk("t2.count", 32'(out_count), 32'd0);
`endif
    step();
    chk_idle("t2.end");

    // A5A5 LSB-first with stalls between beats
    in_vec = 16'hA5A5; in_dir = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_vec = 16'h1234; in_dir = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_beat($sformatf("t3.b%0d", k), exp3[k], logic'(k == 7), 1'b0);
      step();
      chk_beat($sformatf("t3.s%0d", k), exp3[k], logic'(k == 7), 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk_idle("t3.end");

    // FFFF, async reset after third beat
    in_vec = 16'hFFFF; in_dir = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t4.b0", 15, 1'b0, 1'b0);
    step();
    chk_beat("t4.b1", 14, 1'b0, 1'b0);
    step();
    chk_beat("t4.b2", 13, 1'b0, 1'b0);
    step();
    chk_beat("t4.b3", 12, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("t4.rst");
    chk("t4.rst.idx", 32'(out_idx), 32'd0);
    chk("t4.rst.last", 32'(out_last), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    in_vec = 16'h0040; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t4.n0", 6, 1'b1, 1'b0);
    step();
    chk_idle("t4.end");

    // in_vec changes and in_valid held during SCAN
    in_vec = 16'h0003; in_dir = 1'b1; in_valid = 1'b1;
    step();
    in_vec = 16'h8000; in_dir = 1'b0;
    chk_beat("t5.b0", 0, 1'b0, 1'b0);
    step();
    chk_beat("t5.b1", 1, 1'b1, 1'b0);
    step();
    chk_idle("t5.bubble");
    step();
    in_valid = 1'b0;
    chk_beat("t5.n0", 15, 1'b1, 1'b0);
    step();
    chk_idle("t5.end");

    // WIDTH=5 all ones, MSB-first
    v5_vec = 5'b11111; v5_dir = 1'b0; v5_valid = 1'b1; v5_oready = 1'b1;
    step();
    v5_valid = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      chk($sformatf("w5.valid%0d", k), 32'(v5_ovalid), 32'd1);
      chk($sformatf("w5.idx%0d", k),   32'(v5_idx),    32'(k));
      chk($sformatf("w5.last%0d", k),  32'(v5_last),   32'(k == 0));
`ifdef PRIO_SCAN_POPCOUNT_EN
      chk($sformatf("w5.count%0d", k), 32'(v5_count), 32'd5);
`endif
      step();
    end
    chk("w5.end.valid", 32'(v5_ovalid), 32'd0);
    chk("w5.end.rdy",   32'(v5_iready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
